// File: rtl/uart_rx_param_pkg.sv
// rtl/uart_rx_param_pkg.sv - state encodings, parity modes and parity helper for the UART receiver
package uart_rx_param_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_START   = 3'd1;
  localparam state_t ST_DATA    = 3'd2;
  localparam state_t ST_PARITY  = 3'd3;
  localparam state_t ST_STOP    = 3'd4;
  localparam state_t ST_RECOVER = 3'd5;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic calc_parity(input logic [8:0] d, input int mode);
    if (mode == PAR_ODD) begin
      return ~^d;
    end
    if (mode == PAR_EVEN) begin
      return ^d;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - line/enable inputs and word/flag outputs of the UART receiver
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_en;
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break_det;

  modport master (
    output i_en,
    output i_rx,
    input  o_data,
    input  o_valid,
    input  o_busy,
    input  o_parity_err,
    input  o_frame_err,
    input  o_break_det
  );

  modport slave (
    input  i_en,
    input  i_rx,
    output o_data,
    output o_valid,
    output o_busy,
    output o_parity_err,
    output o_frame_err,
    output o_break_det
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser followed by a 3-tap majority vote
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_bit
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_hist;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
      r_hist <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_hist <= {r_hist[1:0], r_sync[SYNC_STAGES-1]};
    end
  end

  assign o_bit = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with parity, framing and break flags
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  uart_rx_param_if.slave bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2 || SYNC_STAGES < 2)
  begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  logic w_bit;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_rx  (bus.i_rx),
    .o_bit (w_bit)
  );

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TICK_W-1:0]     r_tick;
  logic [BIT_W-1:0]      r_bit;
  logic                  r_stop;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_err;
  logic                  r_frm_err;
  logic                  r_all_low;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_par_out;
  logic                  r_frm_out;
  logic                  r_brk_out;

  logic w_half;
  logic w_sample;
  logic w_complete;
  logic w_frm_final;
  logic w_brk_final;
  logic w_par_mismatch;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.i_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (!w_bit) w_state_nxt = ST_START;
        ST_START:   if (w_half) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (w_sample && r_bit == BIT_LAST) begin
            w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY:  if (w_sample) w_state_nxt = ST_STOP;
        ST_STOP:    if (w_complete) w_state_nxt = w_frm_final ? ST_RECOVER : ST_IDLE;
        ST_RECOVER: if (w_bit && w_sample) w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Break needs the first stop bit low; with two stop bits it is already folded into r_all_low.
  always_comb begin
    w_half         = (r_tick == TICK_HALF);
    w_sample       = (r_tick == TICK_LAST);
    w_complete     = (r_state == ST_STOP) && w_sample && (r_stop == STOP_LAST);
    w_frm_final    = r_frm_err | ~w_bit;
    w_brk_final    = r_stop ? r_all_low : (r_all_low & ~w_bit);
    w_par_mismatch = (w_bit != calc_parity(9'(r_shift), PARITY));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick    <= '0;
      r_bit     <= '0;
      r_stop    <= 1'b0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_all_low <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_par_out <= 1'b0;
      r_frm_out <= 1'b0;
      r_brk_out <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_par_out <= 1'b0;
      r_frm_out <= 1'b0;
      r_brk_out <= 1'b0;
      if (!bus.i_en) begin
        r_tick <= '0;
        r_bit  <= '0;
        r_stop <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_tick <= '0;
          ST_START: begin
            if (w_half) begin
              r_tick    <= '0;
              r_bit     <= '0;
              r_stop    <= 1'b0;
              r_par_err <= 1'b0;
              r_frm_err <= 1'b0;
              r_all_low <= 1'b1;
              r_busy    <= ~w_bit;
            end else begin
              r_tick <= r_tick + TICK_ONE;
            end
          end
          ST_DATA: begin
            if (w_sample) begin
              r_tick    <= '0;
              r_bit     <= r_bit + BIT_ONE;
              r_all_low <= r_all_low & ~w_bit;
              for (int i = 0; i < DATA_BITS; i++) begin
                if (r_bit == BIT_W'(i)) r_shift[i] <= w_bit;
              end
            end else begin
              r_tick <= r_tick + TICK_ONE;
            end
          end
          ST_PARITY: begin
            if (w_sample) begin
              r_tick    <= '0;
              r_par_err <= w_par_mismatch;
              r_all_low <= r_all_low & ~w_bit;
            end else begin
              r_tick <= r_tick + TICK_ONE;
            end
          end
          ST_STOP: begin
            if (w_sample) begin
              r_tick <= '0;
              if (w_complete) begin
                r_data    <= r_shift;
                r_valid   <= 1'b1;
                r_busy    <= 1'b0;
                r_par_out <= r_par_err;
                r_frm_out <= w_frm_final;
                r_brk_out <= w_brk_final;
                r_stop    <= 1'b0;
              end else begin
                r_stop    <= 1'b1;
                r_frm_err <= w_frm_final;
                r_all_low <= r_all_low & ~w_bit;
              end
            end else begin
              r_tick <= r_tick + TICK_ONE;
            end
          end
          ST_RECOVER: r_tick <= (w_bit && !w_sample) ? r_tick + TICK_ONE : '0;
          default:    r_tick <= '0;
        endcase
      end
    end
  end

  assign bus.o_data       = r_data;
  assign bus.o_valid      = r_valid;
  assign bus.o_busy       = r_busy;
  assign bus.o_parity_err = r_par_out;
  assign bus.o_frame_err  = r_frm_out;
  assign bus.o_break_det  = r_brk_out;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param in 8N1, 8E1 and 9N2 builds
module tb_uart_rx_param;

  localparam int OS = 16;

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_line [3];
  logic rx_line [3];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   flag_leak = 0;
  int   busy_cnt [3];
  int   busy_last [3];
  int   busy_falls [3];
  rec_t got [$];
  rec_t exp_q [$];
  rec_t mon_r;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(9)) if2 ();

  assign if0.i_en = en_line[0];
  assign if0.i_rx = rx_line[0];
  assign if1.i_en = en_line[1];
  assign if1.i_rx = rx_line[1];
  assign if2.i_en = en_line[2];
  assign if2.i_rx = rx_line[2];

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2))
    u_def (.i_clk(clk), .i_rst(rst), .bus(if0));
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2))
    u_par (.i_clk(clk), .i_rst(rst), .bus(if1));
  uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2))
    u_n92 (.i_clk(clk), .i_rst(rst), .bus(if2));

  logic [8:0] m_data  [3];
  logic       m_valid [3];
  logic       m_busy  [3];
  logic       m_pe    [3];
  logic       m_fe    [3];
  logic       m_bd    [3];

  assign m_data[0] = {1'b0, if0.o_data};
  assign m_data[1] = {1'b0, if1.o_data};
  assign m_data[2] = if2.o_data;
  assign m_valid[0] = if0.o_valid;
  assign m_valid[1] = if1.o_valid;
  assign m_valid[2] = if2.o_valid;
  assign m_busy[0] = if0.o_busy;
  assign m_busy[1] = if1.o_busy;
  assign m_busy[2] = if2.o_busy;
  assign m_pe[0] = if0.o_parity_err;
  assign m_pe[1] = if1.o_parity_err;
  assign m_pe[2] = if2.o_parity_err;
  assign m_fe[0] = if0.o_frame_err;
  assign m_fe[1] = if1.o_frame_err;
  assign m_fe[2] = if2.o_frame_err;
  assign m_bd[0] = if0.o_break_det;
  assign m_bd[1] = if1.o_break_det;
  assign m_bd[2] = if2.o_break_det;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (m_valid[d]) begin
        mon_r.dut  = d;
        mon_r.data = m_data[d];
        mon_r.pe   = m_pe[d];
        mon_r.fe   = m_fe[d];
        mon_r.bd   = m_bd[d];
        got.push_back(mon_r);
      end else if (m_pe[d] || m_fe[d] || m_bd[d]) begin
        flag_leak++;
      end
      if (m_busy[d]) begin
        busy_cnt[d]++;
      end else if (busy_cnt[d] != 0) begin
        busy_last[d] = busy_cnt[d];
        busy_falls[d]++;
        busy_cnt[d] = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    end
  endtask

  function automatic int nbits_of(input int d);
    return (d == 2) ? 9 : 8;
  endfunction

  function automatic int pmode_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  function automatic int nstop_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Builds the line waveform for one frame and queues the outcome the rules predict for it.
  task automatic send(input int d, input logic [8:0] val, input logic pflip, input logic [1:0] stopv);
    int         nb;
    int         pm;
    int         ns;
    logic [8:0] dm;
    logic       odd_ones;
    logic       pbit;
    logic       bits [$];
    rec_t       r;
    nb = nbits_of(d);
    pm = pmode_of(d);
    ns = nstop_of(d);
    dm = val & 9'((1 << nb) - 1);
    odd_ones = ($countones(dm) % 2) == 1;
    pbit = ((pm == 2) ? odd_ones : !odd_ones) ^ pflip;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
    if (pm != 0) bits.push_back(pbit);
    for (int i = 0; i < ns; i++) bits.push_back(stopv[i]);
    foreach (bits[i]) begin
      rx_line[d] = bits[i];
      wait_clks(OS);
    end
    rx_line[d] = 1'b1;
    r.dut  = d;
    r.data = dm;
    r.pe   = (pm != 0) && pflip;
    r.fe   = (ns == 1) ? !stopv[0] : !(stopv[0] && stopv[1]);
    r.bd   = (dm == 9'd0) && (pm == 0 || !pbit) && !stopv[0];
    exp_q.push_back(r);
  endtask

  task automatic partial(input int d, input logic [8:0] val);
    rx_line[d] = 1'b0;
    wait_clks(OS);
    for (int i = 0; i < 4; i++) begin
      rx_line[d] = val[i];
      wait_clks(OS);
    end
    rx_line[d] = val[4];
    wait_clks(OS / 2);
  endtask

  task automatic compare_q(input string tag);
    chk({tag, ".count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk({tag, ".dut"},  32'(got[i].dut),  32'(exp_q[i].dut));
      chk({tag, ".data"}, 32'(got[i].data), 32'(exp_q[i].data));
      chk({tag, ".pe"},   32'(got[i].pe),   32'(exp_q[i].pe));
      chk({tag, ".fe"},   32'(got[i].fe),   32'(exp_q[i].fe));
      chk({tag, ".bd"},   32'(got[i].bd),   32'(exp_q[i].bd));
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    rec_t br;
    int   falls0;
    for (int d = 0; d < 3; d++) begin
      en_line[d]    = 1'b1;
      rx_line[d]    = 1'b1;
      busy_cnt[d]   = 0;
      busy_last[d]  = 0;
      busy_falls[d] = 0;
    end
    wait_clks(2);
    chk("reset.data",  32'(m_data[0]),  0);
    chk("reset.valid", 32'(m_valid[0]), 0);
    chk("reset.busy",  32'(m_busy[0]),  0);
    chk("reset.pe",    32'(m_pe[0]),    0);
    chk("reset.fe",    32'(m_fe[0]),    0);
    chk("reset.bd",    32'(m_bd[0]),    0);
    rst = 1'b0;
    wait_clks(4);

    send(0, 9'h0A5, 1'b0, 2'b11);
    wait_clks(OS);
    compare_q("a5");
    chk("a5.busy_len", 32'(busy_last[0]), 32'((8 + 1) * OS));

    send(1, 9'h007, 1'b0, 2'b11);
    send(1, 9'h007, 1'b1, 2'b11);
    wait_clks(OS);
    compare_q("even_par");

    falls0 = busy_falls[0];
    rx_line[0] = 1'b0;
    wait_clks(4);
    rx_line[0] = 1'b1;
    wait_clks(30);
    chk("glitch.busy_falls", 32'(busy_falls[0] - falls0), 0);
    chk("glitch.busy_now", 32'(m_busy[0]), 0);
    compare_q("glitch");
    send(0, 9'h03C, 1'b0, 2'b11);
    wait_clks(OS);
    compare_q("after_glitch");

    rx_line[0] = 1'b0;
    wait_clks(3 * 10 * OS);
    chk("break.single", 32'(got.size()), 1);
    rx_line[0] = 1'b1;
    wait_clks(8);
    rx_line[0] = 1'b0;
    wait_clks(40);
    rx_line[0] = 1'b1;
    wait_clks(30);
    chk("break.recover_hold", 32'(got.size()), 1);
    br.dut = 0; br.data = 9'd0; br.pe = 1'b0; br.fe = 1'b1; br.bd = 1'b1;
    exp_q.push_back(br);
    send(0, 9'h055, 1'b0, 2'b11);
    wait_clks(OS);
    compare_q("break");

    send(2, 9'h1FF, 1'b0, 2'b01);
    wait_clks(3 * OS);
    compare_q("n92_stop2");

    partial(0, 9'h096);
    chk("rst.busy_before", 32'(m_busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst.data",  32'(m_data[0]),  0);
    chk("rst.busy",  32'(m_busy[0]),  0);
    chk("rst.valid", 32'(m_valid[0]), 0);
    rx_line[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clks(3 * OS);
    compare_q("rst_mid");

    send(0, 9'h05A, 1'b0, 2'b11);
    wait_clks(OS);
    compare_q("pre_en");
    partial(0, 9'h0C3);
    chk("en.busy_before", 32'(m_busy[0]), 1);
    en_line[0] = 1'b0;
    rx_line[0] = 1'b1;
    @(negedge clk);
    chk("en.busy", 32'(m_busy[0]), 0);
    chk("en.data_kept", 32'(m_data[0]), 32'h5A);
    wait_clks(10);
    en_line[0] = 1'b1;
    wait_clks(3 * OS);
    compare_q("en_low");

    send(0, 9'h081, 1'b0, 2'b11);
    send(0, 9'h081, 1'b0, 2'b11);
    wait_clks(OS);
    compare_q("b2b");

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 8; k++) begin
        logic [8:0] v;
        logic       pf;
        logic [1:0] sv;
        v  = 9'($urandom);
        pf = (pmode_of(d) != 0) && ($urandom_range(0, 3) == 0);
        sv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        send(d, v, pf, sv);
        wait_clks((sv != 2'b11) ? 2 * OS + $urandom_range(0, 8) : $urandom_range(0, 20));
      end
      wait_clks(2 * OS);
      compare_q("rand");
    end

    chk("flags_idle", 32'(flag_leak), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
